// File: rtl/jellyvl_etherneco_synctimer_slave.sv
// rtl/jellyvl_etherneco_synctimer_slave.sv - Etherneco sync-timer slave node and its local fractional timer
// Optional feature macro: JELLYVL_SYNCTIMER_SLAVE_CORRECT_EN (single-step timer correction)

module jellyvl_synctimer_timer #(
    parameter int TIMER_WIDTH = 64,
    parameter int NUMERATOR   = 10,
    parameter int DENOMINATOR = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TIMER_WIDTH-1:0] set_time,
    input  logic                   set_valid,
    input  logic                   adjust_sign,
    input  logic                   adjust_valid,
    output logic                   adjust_ready,
    output logic [TIMER_WIDTH-1:0] current_time
);
    // Period NUMERATOR/DENOMINATOR is split into an integer step plus a carry
    // from a remainder accumulator, so the timer never drifts.
    localparam int FRAC_WIDTH = $clog2(2 * DENOMINATOR) + 1;
    localparam logic [FRAC_WIDTH-1:0]  FRAC_STEP = FRAC_WIDTH'(NUMERATOR % DENOMINATOR);
    localparam logic [FRAC_WIDTH-1:0]  FRAC_DEN  = FRAC_WIDTH'(DENOMINATOR);
    localparam logic [TIMER_WIDTH-1:0] INT_STEP  = TIMER_WIDTH'(NUMERATOR / DENOMINATOR);
    localparam logic [TIMER_WIDTH-1:0] ONE       = TIMER_WIDTH'(1);

    logic [FRAC_WIDTH-1:0]  frac;
    logic [FRAC_WIDTH-1:0]  frac_sum;
    logic                   carry;
    logic [TIMER_WIDTH-1:0] step;

    assign adjust_ready = ~set_valid;

    always_comb begin
        frac_sum = frac + FRAC_STEP;
        carry    = (frac_sum >= FRAC_DEN);
        step     = INT_STEP + TIMER_WIDTH'(carry);
        if (adjust_valid && adjust_ready) begin
            step = adjust_sign ? (step - ONE) : (step + ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            current_time <= '0;
            frac         <= '0;
        end else if (set_valid) begin
            current_time <= set_time;
            frac         <= '0;
        end else begin
            current_time <= current_time + step;
            frac         <= carry ? (frac_sum - FRAC_DEN) : frac_sum;
        end
    end
endmodule

module jellyvl_etherneco_synctimer_slave #(
    parameter int TIMER_WIDTH      = 64,
    parameter int NUMERATOR        = 10,
    parameter int DENOMINATOR      = 3,
    parameter int MAX_NODES        = 2,
    parameter int OFFSET_WIDTH     = 24,
    parameter int ADJUST_THRESHOLD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [TIMER_WIDTH-1:0] current_time,
    input  logic                   cmd_rx_start,
    input  logic                   cmd_rx_end,
    input  logic                   cmd_rx_error,
    input  logic [7:0]             cmd_rx_node,
    input  logic [15:0]            cmd_payload_pos,
    input  logic [7:0]             cmd_payload_data,
    input  logic                   cmd_payload_valid,
    input  logic                   ret_rx_start,
    input  logic                   ret_rx_end,
    input  logic                   ret_rx_error,
    input  logic [15:0]            ret_payload_pos,
    input  logic [7:0]             ret_payload_data,
    input  logic                   ret_payload_valid,
    output logic [7:0]             ret_replace_data,
    output logic                   ret_replace_valid
);
    typedef enum logic [1:0] {IDLE, CMD_RX, WAIT_RET, RET_RX} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [7:0]              slot;
    logic                    slot_ok;
    logic                    cmd_renew;
    logic                    cmd_correct;
    logic [TIMER_WIDTH-1:0]  rx_time;
    logic [TIMER_WIDTH-1:0]  local_start;
    logic [TIMER_WIDTH-1:0]  elapsed;
    logic [TIMER_WIDTH-1:0]  set_time;
    logic [OFFSET_WIDTH-1:0] rx_offset;
    logic [OFFSET_WIDTH-1:0] turnaround;
    logic [31:0]             turnaround_ext;
    logic                    measured_valid;
    logic                    cmd_good_end;
    logic                    set_valid;
    logic                    adjust_valid;
    logic                    adjust_sign;
    logic                    adjust_ready;
    logic [15:0]             slot_base;
    logic [15:0]             cmd_slot_off;
    logic [15:0]             ret_slot_off;
    logic                    cmd_slot_hit;
    logic                    ret_slot_hit;
    logic                    unused_ret;

    jellyvl_synctimer_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .set_time     (set_time),
        .set_valid    (set_valid),
        .adjust_sign  (adjust_sign),
        .adjust_valid (adjust_valid),
        .adjust_ready (adjust_ready),
        .current_time (current_time)
    );

    // The return payload is passed through by the ring; only the replace byte is ours.
    assign unused_ret = ^ret_payload_data;

    assign slot_base    = 16'd9 + {6'd0, slot, 2'b00};
    assign cmd_slot_off = cmd_payload_pos - slot_base;
    assign ret_slot_off = ret_payload_pos - slot_base;
    assign cmd_slot_hit = (cmd_payload_pos >= slot_base) && (cmd_slot_off[15:2] == 14'd0);
    assign ret_slot_hit = (ret_payload_pos >= slot_base) && (ret_slot_off[15:2] == 14'd0);

    assign elapsed   = current_time - local_start;
    assign set_time  = rx_time + TIMER_WIDTH'(rx_offset) + elapsed;
    assign set_valid = cmd_good_end & cmd_renew & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        cmd_good_end = 1'b0;
        if (cmd_rx_start) begin
            next_state = CMD_RX;
        end else begin
            case (state)
                CMD_RX: begin
                    if (cmd_rx_end) begin
                        if (cmd_rx_error || !slot_ok) begin
                            next_state = IDLE;
                        end else begin
                            next_state   = WAIT_RET;
                            cmd_good_end = 1'b1;
                        end
                    end
                end
                WAIT_RET: begin
                    if (ret_rx_start) begin
                        next_state = RET_RX;
                    end
                end
                RET_RX: begin
                    if (ret_rx_end || ret_rx_error) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot           <= '0;
            slot_ok        <= 1'b0;
            cmd_renew      <= 1'b0;
            cmd_correct    <= 1'b0;
            rx_time        <= '0;
            rx_offset      <= '0;
            local_start    <= '0;
            turnaround     <= '0;
            measured_valid <= 1'b0;
        end else if (cmd_rx_start) begin
            slot           <= cmd_rx_node - 8'd1;
            slot_ok        <= (cmd_rx_node != 8'd0) && (int'(cmd_rx_node) <= MAX_NODES);
            cmd_renew      <= 1'b0;
            cmd_correct    <= 1'b0;
            rx_time        <= '0;
            rx_offset      <= '0;
            local_start    <= current_time;
            turnaround     <= '0;
            measured_valid <= 1'b0;
        end else begin
            if (state == CMD_RX && cmd_payload_valid) begin
                if (cmd_payload_pos == 16'd0) begin
                    cmd_correct <= cmd_payload_data[0];
                    cmd_renew   <= cmd_payload_data[1];
                end
                // Little-endian byte lanes; bits beyond the register width are dropped.
                for (int b = 0; b < TIMER_WIDTH; b++) begin
                    if (cmd_payload_pos == 16'(b / 8 + 1)) begin
                        rx_time[b] <= cmd_payload_data[b % 8];
                    end
                end
                if (cmd_slot_hit) begin
                    for (int b = 0; b < OFFSET_WIDTH; b++) begin
                        if (cmd_slot_off[1:0] == 2'(b / 8)) begin
                            rx_offset[b] <= cmd_payload_data[b % 8];
                        end
                    end
                end
            end
            if (state == WAIT_RET && ret_rx_start) begin
                turnaround     <= elapsed[OFFSET_WIDTH-1:0];
                measured_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        ret_replace_valid = 1'b0;
        ret_replace_data  = 8'd0;
        turnaround_ext    = 32'(turnaround);
        if (ret_payload_valid && state == RET_RX && measured_valid && ret_slot_hit) begin
            ret_replace_valid = 1'b1;
            ret_replace_data  = turnaround_ext[{ret_slot_off[1:0], 3'b000} +: 8];
        end
    end

`ifdef JELLYVL_SYNCTIMER_SLAVE_CORRECT_EN
    logic signed [OFFSET_WIDTH-1:0] err;
    logic        [OFFSET_WIDTH-1:0] err_mag;
    logic                           adjust_start;

    always_comb begin
        err          = signed'(rx_time[OFFSET_WIDTH-1:0] + rx_offset - local_start[OFFSET_WIDTH-1:0]);
        err_mag      = err[OFFSET_WIDTH-1] ? OFFSET_WIDTH'(-err) : OFFSET_WIDTH'(err);
        adjust_start = cmd_good_end && cmd_correct && !cmd_renew
                       && ({1'b0, err_mag} >= (OFFSET_WIDTH + 1)'(ADJUST_THRESHOLD));
    end

    // One correction step per command, held until the timer takes it.
    always_ff @(posedge clk) begin
        if (rst || cmd_rx_start) begin
            adjust_valid <= 1'b0;
            adjust_sign  <= 1'b0;
        end else if (adjust_start) begin
            adjust_valid <= 1'b1;
            adjust_sign  <= err[OFFSET_WIDTH-1];
        end else if (adjust_ready) begin
            adjust_valid <= 1'b0;
        end
    end
`else
    logic unused_adjust;

    assign adjust_valid  = 1'b0;
    assign adjust_sign   = 1'b0;
    assign unused_adjust = adjust_ready ^ cmd_correct;
`endif
endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave.sv
// tb/tb_jellyvl_etherneco_synctimer_slave.sv - directed-vector bench for the sync-timer slave
module tb_jellyvl_etherneco_synctimer_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] current_time;
    logic        cmd_rx_start;
    logic        cmd_rx_end;
    logic        cmd_rx_error;
    logic [7:0]  cmd_rx_node;
    logic [15:0] cmd_payload_pos;
    logic [7:0]  cmd_payload_data;
    logic        cmd_payload_valid;
    logic        ret_rx_start;
    logic        ret_rx_end;
    logic        ret_rx_error;
    logic [15:0] ret_payload_pos;
    logic [7:0]  ret_payload_data;
    logic        ret_payload_valid;
    logic [7:0]  ret_replace_data;
    logic        ret_replace_valid;

    logic [63:0] ncyc;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    // Cycles since the last reset edge; nominal time is floor(ncyc * 10 / 3).
    always @(posedge clk) ncyc <= rst ? 64'd0 : ncyc + 64'd1;

    jellyvl_etherneco_synctimer_slave dut (
        .clk               (clk),
        .rst               (rst),
        .current_time      (current_time),
        .cmd_rx_start      (cmd_rx_start),
        .cmd_rx_end        (cmd_rx_end),
        .cmd_rx_error      (cmd_rx_error),
        .cmd_rx_node       (cmd_rx_node),
        .cmd_payload_pos   (cmd_payload_pos),
        .cmd_payload_data  (cmd_payload_data),
        .cmd_payload_valid (cmd_payload_valid),
        .ret_rx_start      (ret_rx_start),
        .ret_rx_end        (ret_rx_end),
        .ret_rx_error      (ret_rx_error),
        .ret_payload_pos   (ret_payload_pos),
        .ret_payload_data  (ret_payload_data),
        .ret_payload_valid (ret_payload_valid),
        .ret_replace_data  (ret_replace_data),
        .ret_replace_valid (ret_replace_valid)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_nominal(input string tag);
        expect_eq(tag, current_time, (ncyc * 64'd10) / 64'd3);
    endtask

    // Start pulse sampled at edge E0, payload bytes 0..16 at E1..E17.
    task automatic cmd_begin(input logic [7:0] node, input logic [7:0] cmd, input logic [63:0] t,
                             input logic [31:0] off0, input logic [31:0] off1);
        logic [7:0] pl [0:16];
        pl[0] = cmd;
        for (int i = 0; i < 8; i++) pl[1 + i] = t[8 * i +: 8];
        for (int j = 0; j < 4; j++) begin
            pl[9 + j]  = off0[8 * j +: 8];
            pl[13 + j] = off1[8 * j +: 8];
        end
        cmd_rx_start = 1'b1;
        cmd_rx_node  = node;
        step();
        cmd_rx_start = 1'b0;
        for (int p = 0; p < 17; p++) begin
            cmd_payload_valid = 1'b1;
            cmd_payload_pos   = 16'(p);
            cmd_payload_data  = pl[p];
            step();
        end
        cmd_payload_valid = 1'b0;
    endtask

    task automatic cmd_finish(input int wait_n, input logic err);
        repeat (wait_n) step();
        cmd_rx_end   = 1'b1;
        cmd_rx_error = err;
        step();
        cmd_rx_end   = 1'b0;
        cmd_rx_error = 1'b0;
    endtask

    // Return packet of 21 bytes; base < 0 means no byte may be replaced.
    task automatic ret_packet(input string tag, input int pre, input int base,
                              input logic [31:0] val, input int rst_pos);
        bit         dead = 1'b0;
        bit         hit;
        logic [7:0] eb;
        repeat (pre) step();
        ret_rx_start = 1'b1;
        step();
        ret_rx_start = 1'b0;
        for (int p = 0; p < 21; p++) begin
            ret_payload_valid = 1'b1;
            ret_payload_pos   = 16'(p);
            ret_payload_data  = 8'hA0 + 8'(p);
            if (p == rst_pos) rst = 1'b1;
            #1;
            hit = !dead && base >= 0 && p >= base && p < base + 4;
            eb  = 8'd0;
            if (hit) eb = val[8 * (p - base) +: 8];
            if (p != rst_pos) begin
                expect_eq({tag, " replace_valid"}, {63'd0, ret_replace_valid}, {63'd0, hit});
                expect_eq({tag, " replace_data"}, {56'd0, ret_replace_data}, {56'd0, eb});
            end
            step();
            if (p == rst_pos) begin
                rst  = 1'b0;
                dead = 1'b1;
                expect_eq({tag, " time after reset"}, current_time, 64'd0);
            end
        end
        ret_payload_valid = 1'b0;
        ret_rx_end = 1'b1;
        step();
        ret_rx_end = 1'b0;
    endtask

    initial begin
        logic [7:0] bad_node [0:2];
        logic       bad_err  [0:2];
        bad_node[0] = 8'd1; bad_err[0] = 1'b1;
        bad_node[1] = 8'd0; bad_err[1] = 1'b0;
        bad_node[2] = 8'd3; bad_err[2] = 1'b0;

        cmd_rx_start = 0; cmd_rx_end = 0; cmd_rx_error = 0; cmd_rx_node = 0;
        cmd_payload_pos = 0; cmd_payload_data = 0; cmd_payload_valid = 0;
        ret_rx_start = 0; ret_rx_end = 0; ret_rx_error = 0;
        ret_payload_pos = 0; ret_payload_data = 0; ret_payload_valid = 0;

        // reset state and free-running rate
        do_reset();
        expect_eq("reset time", current_time, 64'd0);
        expect_eq("reset replace_valid", {63'd0, ret_replace_valid}, 64'd0);
        expect_eq("reset replace_data", {56'd0, ret_replace_data}, 64'd0);
        ret_payload_valid = 1'b1; ret_payload_pos = 16'd9; ret_payload_data = 8'h55;
        #1;
        expect_eq("idle no replace", {63'd0, ret_replace_valid}, 64'd0);
        ret_payload_valid = 1'b0;
        repeat (10) step();
        expect_nominal("nominal 10 cycles");

        // renew
        do_reset();
        cmd_begin(8'd1, 8'h02, 64'h1000, 32'd100, 32'd0);
        cmd_finish(12, 1'b0);
        expect_eq("renew node1", current_time, 64'h10C8);
        do_reset();
        cmd_begin(8'd2, 8'h03, 64'h2000, 32'd5, 32'd50);
        cmd_finish(12, 1'b0);
        expect_eq("renew node2 over correct", current_time, 64'h2096);

        // return replace, turnaround 90 cycles = 300
        do_reset();
        cmd_begin(8'd1, 8'h00, 64'h0, 32'd0, 32'd0);
        cmd_finish(12, 1'b0);
        expect_nominal("no-op cmd keeps time");
        ret_packet("ret node1", 59, 9, 32'd300, -1);
        do_reset();
        cmd_begin(8'd2, 8'h00, 64'h0, 32'd0, 32'd0);
        cmd_finish(12, 1'b0);
        ret_packet("ret node2", 59, 13, 32'd300, -1);

        // error and out-of-range node
        for (int k = 0; k < 3; k++) begin
            do_reset();
            cmd_begin(bad_node[k], 8'h02, 64'h1000, 32'd100, 32'd100);
            cmd_finish(12, bad_err[k]);
            expect_nominal($sformatf("bad cmd %0d no set", k));
            ret_packet($sformatf("bad cmd %0d ret", k), 59, -1, 32'd0, -1);
        end

        // correct bit alone leaves the timer on its nominal course
        do_reset();
        cmd_begin(8'd1, 8'h01, 64'h1234, 32'd0, 32'd0);
        cmd_finish(12, 1'b0);
        expect_nominal("correct ignored end");
        repeat (6) step();
        expect_nominal("correct ignored later");

        // back-to-back commands; return during CMD_RX passes through
        do_reset();
        cmd_begin(8'd1, 8'h00, 64'h0, 32'd0, 32'd0);
        cmd_finish(12, 1'b0);
        repeat (5) step();
        cmd_begin(8'd1, 8'h00, 64'h0, 32'd0, 32'd0);
        ret_packet("ret during cmd", 0, -1, 32'd0, -1);
        cmd_finish(0, 1'b0);
        ret_packet("ret after second cmd", 18, 9, 32'd200, -1);

        // reset in the middle of a return packet
        do_reset();
        cmd_begin(8'd1, 8'h00, 64'h0, 32'd0, 32'd0);
        cmd_finish(12, 1'b0);
        ret_packet("ret reset", 59, 9, 32'd300, 10);
        expect_nominal("time after mid-packet reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
